// File: rtl/alu_cmd_issuer.sv
// Command issuer for the 4-bit combinational ALU: launches operands, waits a settle window,
// captures the result into an accumulator/response register. Define ALU_CMD_ISSUER_OVF_EN for res_ovf.
module alu_cmd_issuer #(
    parameter int                DATA_W        = 4,
    parameter int                SETTLE_CYCLES = 1,
    parameter logic [DATA_W-1:0] ACC_RESET     = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic              cmd_use_acc,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic              cmd_wb,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_y,
    input  logic              alu_cout,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_y,
    output logic              res_cout,
    output logic              res_zero,
    output logic [DATA_W-1:0] acc_out
`ifdef ALU_CMD_ISSUER_OVF_EN
    ,
    output logic              res_ovf
`endif
);

    typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

    state_t            state_q;
    state_t            state_d;
    logic [3:0]        cnt;
    logic              wb_pending;
    logic [DATA_W-1:0] acc;
    logic              accept;
    logic              sample;

    function automatic logic is_zero(input logic [DATA_W-1:0] v);
        return v == '0;
    endfunction

`ifdef ALU_CMD_ISSUER_OVF_EN
    // Two's-complement overflow judged from sign bits of the launched operands and the ALU result.
    function automatic logic ovf_flag(input logic [2:0] sel, input logic [DATA_W-1:0] a,
                                      input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] y);
        case (sel)
            3'b000:  return (a[DATA_W-1] == b[DATA_W-1]) && (y[DATA_W-1] != a[DATA_W-1]);
            3'b001:  return (a[DATA_W-1] != b[DATA_W-1]) && (y[DATA_W-1] != a[DATA_W-1]);
            default: return 1'b0;
        endcase
    endfunction
`endif

    assign cmd_ready = rst_n && ((state_q == IDLE) || ((state_q == RESP) && res_ready));
    assign accept    = cmd_valid && cmd_ready;
    assign sample    = (state_q == SETTLE) && (cnt == 4'd0);
    assign acc_out   = acc;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SETTLE;
            SETTLE:  if (cnt == 4'd0) state_d = RESP;
            RESP:    if (res_ready) state_d = accept ? SETTLE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt        <= 4'd0;
            wb_pending <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= 3'd0;
            res_y      <= '0;
            res_cout   <= 1'b0;
            res_zero   <= 1'b0;
            res_valid  <= 1'b0;
            acc        <= ACC_RESET;
`ifdef ALU_CMD_ISSUER_OVF_EN
            res_ovf    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;

            // Launch: acc already holds any writeback from the previous op, so forwarding is free.
            if (accept) begin
                alu_a      <= cmd_use_acc ? acc : cmd_a;
                alu_b      <= cmd_b;
                alu_sel    <= cmd_op;
                wb_pending <= cmd_wb;
                cnt        <= 4'(SETTLE_CYCLES - 1);
            end else if ((state_q == SETTLE) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end

            // Capture at the end of the settle window
            if (sample) begin
                res_y    <= alu_y;
                res_cout <= alu_cout;
                res_zero <= is_zero(alu_y);
`ifdef ALU_CMD_ISSUER_OVF_EN
                res_ovf  <= ovf_flag(alu_sel, alu_a, alu_b, alu_y);
`endif
                if (wb_pending) acc <= alu_y;
            end

            if (sample) begin
                res_valid <= 1'b1;
            end else if ((state_q == RESP) && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Randomized bench for alu_cmd_issuer against a transaction-level model (default build plus a
// SETTLE_CYCLES=3 instance for settle timing and reset-abort behaviour).
module tb_alu_cmd_issuer;

    localparam int W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (default parameters)
    logic         rst_n, cmd_valid, cmd_ready, cmd_use_acc, cmd_wb;
    logic [2:0]   cmd_op, alu_sel;
    logic [W-1:0] cmd_a, cmd_b, alu_a, alu_b, alu_y, res_y, acc_out;
    logic         alu_cout, res_valid, res_ready, res_cout, res_zero;
`ifdef ALU_CMD_ISSUER_OVF_EN
    logic         res_ovf;
`endif

    // Second instance: SETTLE_CYCLES=3, ACC_RESET=3
    logic         rst3_n, cmd_valid3, cmd_ready3, cmd_use_acc3, cmd_wb3;
    logic [2:0]   cmd_op3, alu_sel3;
    logic [W-1:0] cmd_a3, cmd_b3, alu_a3, alu_b3, alu_y3, res_y3, acc_out3;
    logic         alu_cout3, res_valid3, res_ready3, res_cout3, res_zero3;
`ifdef ALU_CMD_ISSUER_OVF_EN
    logic         res_ovf3;
`endif

    // Behavioural ALU: {c_out, y}; c_out is carry for add, borrow for sub.
    function automatic logic [W:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] s);
        case (s)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {(a < b), W'(a - b)};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            3'd5:    return {1'b0, ~a};
            3'd6:    return {1'b0, W'(a << b[1:0])};
            default: return {1'b0, a >> b[1:0]};
        endcase
    endfunction

    function automatic logic ovf_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic [2:0] s);
        int sa, sb, r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (s == 3'd0) r = sa + sb;
        else if (s == 3'd1) r = sa - sb;
        else return 1'b0;
        return (r > (2 ** (W - 1)) - 1) || (r < -(2 ** (W - 1)));
    endfunction

    assign {alu_cout, alu_y}   = alu_ref(alu_a, alu_b, alu_sel);
    assign {alu_cout3, alu_y3} = alu_ref(alu_a3, alu_b3, alu_sel3);

    alu_cmd_issuer u_dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_use_acc(cmd_use_acc), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .cmd_wb(cmd_wb), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_y(alu_y),
        .alu_cout(alu_cout), .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y),
        .res_cout(res_cout), .res_zero(res_zero), .acc_out(acc_out)
`ifdef ALU_CMD_ISSUER_OVF_EN
        , .res_ovf(res_ovf)
`endif
    );

    alu_cmd_issuer #(.DATA_W(W), .SETTLE_CYCLES(3), .ACC_RESET(4'd3)) u_dut3 (
        .clk(clk), .rst_n(rst3_n), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
        .cmd_op(cmd_op3), .cmd_use_acc(cmd_use_acc3), .cmd_a(cmd_a3), .cmd_b(cmd_b3),
        .cmd_wb(cmd_wb3), .alu_a(alu_a3), .alu_b(alu_b3), .alu_sel(alu_sel3), .alu_y(alu_y3),
        .alu_cout(alu_cout3), .res_valid(res_valid3), .res_ready(res_ready3), .res_y(res_y3),
        .res_cout(res_cout3), .res_zero(res_zero3), .acc_out(acc_out3)
`ifdef ALU_CMD_ISSUER_OVF_EN
        , .res_ovf(res_ovf3)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model state: accumulator plus the result currently parked in the response slot
    logic [W-1:0] m_acc;
    bit           have_pending;
    logic [W-1:0] e_y;
    logic         e_c;

    task automatic drain(input int bp);
        for (int i = 0; i < bp; i++) begin
            chk("drain_hold_valid", res_valid, 1);
            chk("drain_hold_y", res_y, e_y);
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("retire_valid", res_valid, 0);
        chk("idle_ready", cmd_ready, 1);
        have_pending = 1'b0;
    endtask

    task automatic send(input logic [2:0] op, input logic ua, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic wb, input int bp, input bit keep);
        logic [W-1:0] ea;
        logic [W:0]   r;
        int           cyc;
        cmd_op = op; cmd_use_acc = ua; cmd_a = a; cmd_b = b; cmd_wb = wb;
        cmd_valid = 1'b1;
        if (have_pending) begin
            for (int i = 0; i < bp; i++) begin
                chk("bp_cmd_ready", cmd_ready, 0);
                chk("bp_res_valid", res_valid, 1);
                chk("bp_res_y", res_y, e_y);
                chk("bp_res_cout", res_cout, e_c);
                @(posedge clk); #1;
            end
            res_ready = 1'b1;
        end
        #1;
        chk("cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        have_pending = 1'b0;
        ea = ua ? m_acc : a;
        r  = alu_ref(ea, b, op);
        chk("alu_a", alu_a, ea);
        chk("alu_b", alu_b, b);
        chk("alu_sel", alu_sel, op);
        chk("settle_valid", res_valid, 0);
        cyc = 0;
        while (!res_valid && cyc < 20) begin
            chk("settle_hold_a", alu_a, ea);
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", cyc, 1);
        chk("res_y", res_y, r[W-1:0]);
        chk("res_cout", res_cout, r[W]);
        chk("res_zero", res_zero, r[W-1:0] == '0);
`ifdef ALU_CMD_ISSUER_OVF_EN
        chk("res_ovf", res_ovf, ovf_ref(ea, b, op));
`endif
        if (wb) m_acc = r[W-1:0];
        chk("acc_out", acc_out, m_acc);
        e_y = r[W-1:0];
        e_c = r[W];
        have_pending = 1'b1;
        if (!keep) drain(bp);
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_use_acc = 1'b0;
        cmd_a = '0; cmd_b = '0; cmd_wb = 1'b0; res_ready = 1'b0;
        rst3_n = 1'b0; cmd_valid3 = 1'b0; cmd_op3 = 3'd0; cmd_use_acc3 = 1'b0;
        cmd_a3 = '0; cmd_b3 = '0; cmd_wb3 = 1'b0; res_ready3 = 1'b0;
        m_acc = '0; have_pending = 1'b0; e_y = '0; e_c = 1'b0;

        #12;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_acc", acc_out, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_sel", alu_sel, 0);
        chk("rst_res_y", res_y, 0);
        chk("rst3_acc", acc_out3, 3);
        chk("rst3_cmd_ready", cmd_ready3, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", cmd_ready, 1);

        // Directed: basic add, subtract with borrow
        send(3'd0, 1'b0, 4'd9, 4'd8, 1'b0, 0, 1'b1);
        chk("add_y", res_y, 4'h1); chk("add_cout", res_cout, 1); chk("add_zero", res_zero, 0);
        chk("add_acc", acc_out, 0);
        drain(0);
        send(3'd1, 1'b0, 4'd3, 4'd5, 1'b0, 1, 1'b1);
        chk("sub_y", res_y, 4'hE); chk("sub_cout", res_cout, 1);
        drain(2);
`ifdef ALU_CMD_ISSUER_OVF_EN
        send(3'd0, 1'b0, 4'd7, 4'd1, 1'b0, 0, 1'b1);
        chk("ovf_y", res_y, 4'h8); chk("ovf_flag", res_ovf, 1);
        drain(0);
`endif

        // Accumulate chain, back-to-back with forwarding
        send(3'd0, 1'b1, 4'd0, 4'd7, 1'b1, 0, 1'b1); chk("chain_add", acc_out, 4'h7);
        send(3'd6, 1'b1, 4'd0, 4'd1, 1'b1, 0, 1'b1); chk("chain_shl", acc_out, 4'hE);
        send(3'd4, 1'b1, 4'd0, 4'hF, 1'b1, 0, 1'b1); chk("chain_xor", acc_out, 4'h1);
        send(3'd5, 1'b1, 4'd0, 4'd0, 1'b1, 0, 1'b1); chk("chain_not", acc_out, 4'hE);
        send(3'd2, 1'b1, 4'd0, 4'd0, 1'b1, 0, 1'b1); chk("chain_and", acc_out, 4'h0);
        chk("chain_zero", res_zero, 1);

        // Backpressure: 5 cycles with a new command waiting, then retire+accept on one edge
        send(3'd0, 1'b0, 4'd2, 4'd3, 1'b0, 5, 1'b0);
        drain(0);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            send(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), W'($urandom),
                 W'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 bit'($urandom_range(0, 1)));
        end
        if (have_pending) drain(0);

        // SETTLE_CYCLES=3 instance: latency, forwarding and reset abort
        @(posedge clk); #1;
        rst3_n = 1'b1;
        cmd_op3 = 3'd0; cmd_use_acc3 = 1'b0; cmd_a3 = 4'd5; cmd_b3 = 4'd0; cmd_wb3 = 1'b1;
        cmd_valid3 = 1'b1;
        #1;
        chk("s3_cmd_ready", cmd_ready3, 1);
        @(posedge clk); #1;
        cmd_valid3 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("s3_hold_a", alu_a3, 4'd5);
            chk("s3_early_valid", res_valid3, 0);
            @(posedge clk); #1;
        end
        chk("s3_valid", res_valid3, 1);
        chk("s3_res_y", res_y3, 4'd5);
        chk("s3_acc", acc_out3, 4'd5);
        res_ready3 = 1'b1;
        @(posedge clk); #1;
        res_ready3 = 1'b0;
        chk("s3_retire", res_valid3, 0);

        cmd_op3 = 3'd0; cmd_use_acc3 = 1'b1; cmd_a3 = 4'd0; cmd_b3 = 4'd1; cmd_wb3 = 1'b1;
        cmd_valid3 = 1'b1;
        @(posedge clk); #1;
        cmd_valid3 = 1'b0;
        chk("s3_fwd_a", alu_a3, 4'd5);
        @(posedge clk); #1;
        rst3_n = 1'b0;
        #1;
        chk("abort_acc", acc_out3, 4'd3);
        chk("abort_valid", res_valid3, 0);
        chk("abort_ready", cmd_ready3, 0);
        chk("abort_alu_a", alu_a3, 0);
        @(posedge clk);
        @(posedge clk); #1;
        rst3_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("abort_no_result", res_valid3, 0);
            chk("abort_acc_hold", acc_out3, 4'd3);
        end
        chk("abort_idle_ready", cmd_ready3, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Sequential initiator that drives the team's 4-bit combinational ALU and collects its result. The ALU uses sel encoding 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not A, 110 shl by B[1:0], 111 shr by B[1:0], with c_out valid only for add and sub.
- Accepts operation commands over a valid/ready handshake and holds ALU operands stable for a settle window.
- Samples y/c_out, optionally writes the result into an internal accumulator, and returns the result with flags over a second valid/ready handshake.

Parameters:
- DATA_W, 4: operand/result width; must equal the ALU width.
- SETTLE_CYCLES, 1: cycles between operand launch and result sample; legal range 1..15.
- ACC_RESET, 0: accumulator value after reset.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when valid&ready.
- cmd_op  in  3  ALU sel code.
- cmd_use_acc  in  1  1: operand A = accumulator; 0: A = cmd_a.
- cmd_a  in  DATA_W  explicit A operand.
- cmd_b  in  DATA_W  B operand (shift amount = cmd_b[1:0]).
- cmd_wb  in  1  write result into accumulator.
- alu_a  out  DATA_W  to ALU A.
- alu_b  out  DATA_W  to ALU B.
- alu_sel  out  3  to ALU sel.
- alu_y  in  DATA_W  from ALU y.
- alu_cout  in  1  from ALU c_out.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed when valid&ready.
- res_y  out  DATA_W  captured result.
- res_cout  out  1  captured alu_cout, passed as-is (carry for add, borrow for sub, 0 otherwise).
- res_zero  out  1  res_y == 0.
- acc_out  out  DATA_W  current accumulator.

Behaviour:
- States: IDLE, SETTLE, RESP.
- Reset (async, rst_n low):
  - State goes to IDLE; cmd_ready forced 0 while rst_n is low.
  - alu_a, alu_b, alu_sel, res_y, res_cout, res_zero and res_valid all go to 0; accumulator goes to ACC_RESET.
  - Reset mid-operation aborts the operation: no result is produced and no accumulator write occurs.
- cmd_ready is combinational: 1 in IDLE, or 1 in RESP when res_ready=1 (back-to-back acceptance); 0 otherwise.
- Accept (cmd_valid & cmd_ready at an edge):
  - Registers alu_a (the accumulator value if cmd_use_acc, else cmd_a), alu_b = cmd_b, alu_sel = cmd_op, and wb_pending = cmd_wb.
  - Loads the settle counter with SETTLE_CYCLES-1; goes to SETTLE.
- SETTLE: alu_* held constant. Counter decrements each cycle. At the edge where the counter is 0:
  - res_y <= alu_y; res_cout <= alu_cout; res_zero <= (alu_y == 0).
  - If wb_pending, the accumulator takes alu_y on the same edge.
  - res_valid goes to 1; state goes to RESP.
- Latency: res_valid rises SETTLE_CYCLES cycles after the accept edge; default is the cycle after accept.
- RESP: res_* held stable while res_ready=0 (no change under backpressure).
  - res_ready=1 with no new command: res_valid drops and state goes to IDLE.
  - res_ready=1 with cmd_valid=1: result retires and the new command is accepted on the same edge; state goes to SETTLE and res_valid drops for the settle window.
- Accumulator forwarding: a command with cmd_use_acc sees any writeback from the previous operation, because writeback completes before acceptance is possible.
- Arithmetic: result width is DATA_W, wraps modulo 2^DATA_W (performed by the ALU). The block does no arithmetic except the zero compare.
- alu_* keep their last values in IDLE/RESP; they are not cleared.
- Undefined cmd_op values do not exist (3-bit full decode).

Optional Feature:
- Macro: ALU_CMD_ISSUER_OVF_EN.
- Defined:
  - Adds output res_ovf (1 bit, reset 0), captured with res_y.
  - For op 000: res_ovf = (alu_a[MSB]==alu_b[MSB]) & (alu_y[MSB]!=alu_a[MSB]).
  - For op 001: res_ovf = (alu_a[MSB]!=alu_b[MSB]) & (alu_y[MSB]!=alu_a[MSB]).
  - For all other ops: res_ovf = 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Basic add: reset, then cmd op=000 use_acc=0 a=9 b=8 wb=0 → next cycle res_valid=1, res_y=1, res_cout=1, res_zero=0; acc_out stays 0.
- Subtract with borrow: op=001 a=3 b=5 → res_y=E, res_cout=1. With OVF_EN: op=000 a=7 b=1 → res_y=8, res_ovf=1.
- Accumulate chain, all wb=1 use_acc=1 from acc=0:
  - add b=7 → acc=7; shl b=1 → acc=E; xor b=F → acc=1; not → acc=E; and b=0 → acc=0, res_zero=1.
- Backpressure: hold res_ready=0 for 5 cycles with cmd_valid=1 → res_* stable and cmd_ready=0. Raise res_ready → old result retires and the new command is accepted on the same edge.
- SETTLE_CYCLES=3 build: accept at edge N → alu_* stable for 3 cycles, res_valid rises at edge N+3 and not before.
- Reset mid-op: assert rst_n=0 during SETTLE with wb=1, acc=5 → acc_out=ACC_RESET, res_valid=0, and no result is delivered after release.
